// File: rtl/riscv_dmem_responder.sv
// Data-memory target for the CPU MEM-stage port: word RAM with byte-strobe
// writes, completed over a 4-phase req/ack handshake behind a req synchroniser.
module riscv_dmem_responder #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_dmem_req,
    input  logic [XLEN-1:0] i_dmem_addr,
    input  logic            i_dmem_wr_en,
    input  logic [3:0]      i_dmem_strb,
    input  logic [XLEN-1:0] i_dmem_wr_data,
    output logic            o_dmem_ack,
    output logic [XLEN-1:0] o_dmem_rd_data,
    output logic            o_dmem_err,
    output logic            o_dmem_busy
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned IDX_MSB = DEPTH_LOG2 + 1;
    localparam int unsigned HI_LSB  = DEPTH_LOG2 + 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_ACK    = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s_c;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   load_c, access_c, drop_c;

    logic [DEPTH_LOG2-1:0]  idx_q;
    logic                   wen_q, oor_q;
    logic [3:0]             strb_q;
    logic [XLEN-1:0]        wdata_q;

    logic                   ack_q, err_q, busy_q;
    logic [XLEN-1:0]        rd_q;

    logic [XLEN-1:0]        mem [DEPTH];
    logic [XLEN-1:0]        mem_word_c, merged_c;
    logic                   mem_we_c;

    // Byte-offset bits are don't-care for a word-organised array.
    logic                   unused_addr_c;
    assign unused_addr_c = ^i_dmem_addr[1:0];

    // Request synchroniser; the FSM only ever looks at its last stage.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_dmem_req};
        end
    end
    assign req_s_c = sync_q[SYNC_STAGES-1];

    // FSM state and wait-state counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept from IDLE only, wait out latency, hold ack until req low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_c   = 1'b0;
        access_c = 1'b0;
        drop_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_s_c) begin
                    load_c  = 1'b1;
                    cnt_d   = CNT_W'(RD_LATENCY);
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access_c = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                if (!req_s_c) begin
                    drop_c  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request payload and range check when it is accepted.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            idx_q   <= '0;
            wen_q   <= 1'b0;
            oor_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else if (load_c) begin
            idx_q   <= i_dmem_addr[IDX_MSB:2];
            wen_q   <= i_dmem_wr_en;
            oor_q   <= (i_dmem_addr[XLEN-1:HI_LSB] != '0);
            strb_q  <= i_dmem_strb;
            wdata_q <= i_dmem_wr_data;
        end
    end

    // Current word with strobed lanes replaced by the write data.
    always_comb begin
        mem_word_c = mem[idx_q];
        merged_c   = mem_word_c;
        for (int i = 0; i < 4; i++) begin
            if (strb_q[i]) begin
                merged_c[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    assign mem_we_c = access_c & wen_q & ~oor_q;

    // Storage array: not reset, written only at the end of ACCESS.
    always_ff @(posedge i_clk) begin
        if (mem_we_c) begin
            mem[idx_q] <= merged_c;
        end
    end

    // Registered handshake outputs; rd_data survives the return to IDLE.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rd_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            if (access_c) begin
                ack_q <= 1'b1;
                err_q <= oor_q;
                if (oor_q) begin
                    rd_q <= '0;
                end else if (wen_q) begin
                    rd_q <= merged_c;
                end else begin
                    rd_q <= mem_word_c;
                end
            end else if (drop_c) begin
                ack_q <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end

    assign o_dmem_ack     = ack_q;
    assign o_dmem_rd_data = rd_q;
    assign o_dmem_err     = err_q;
    assign o_dmem_busy    = busy_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: default instance (A) and a slow instance
// (B: RD_LATENCY=7, SYNC_STAGES=3) checked against a word-map memory model.
module tb_riscv_dmem_responder;

    localparam int A_RISE = 2 + 1 + 2;
    localparam int A_FALL = 2 + 1;
    localparam int B_RISE = 3 + 7 + 2;
    localparam int B_FALL = 3 + 1;

    logic        clk;
    logic        rstn_a, rstn_b;
    logic        req_a, req_b;
    logic [31:0] addr, wdata;
    logic        wen;
    logic [3:0]  strb;
    logic        ack_a, err_a, busy_a, ack_b, err_b, busy_b;
    logic [31:0] rd_a, rd_b;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] mdl [int];

    riscv_dmem_responder dut_a (
        .i_clk(clk), .i_rstn(rstn_a), .i_dmem_req(req_a), .i_dmem_addr(addr),
        .i_dmem_wr_en(wen), .i_dmem_strb(strb), .i_dmem_wr_data(wdata),
        .o_dmem_ack(ack_a), .o_dmem_rd_data(rd_a), .o_dmem_err(err_a), .o_dmem_busy(busy_a)
    );

    riscv_dmem_responder #(.RD_LATENCY(7), .SYNC_STAGES(3)) dut_b (
        .i_clk(clk), .i_rstn(rstn_b), .i_dmem_req(req_b), .i_dmem_addr(addr),
        .i_dmem_wr_en(wen), .i_dmem_strb(strb), .i_dmem_wr_data(wdata),
        .o_dmem_ack(ack_b), .o_dmem_rd_data(rd_b), .o_dmem_err(err_b), .o_dmem_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    function automatic bit out_of_range(input logic [31:0] a);
        return (a >> 12) != 32'h0;
    endfunction

    function automatic logic cur_ack(input bit sel);
        return sel ? ack_b : ack_a;
    endfunction

    // One complete 4-phase transaction; rise/fall are edge counts to ack change.
    task automatic txn(input bit sel, input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int rise, output int fall);
        @(negedge clk);
        addr = a; wen = w; strb = s; wdata = d;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        rise = 0;
        do begin @(posedge clk); #1; rise++; end while (!cur_ack(sel) && rise < 60);
        rd = sel ? rd_b : rd_a;
        er = sel ? err_b : err_a;
        @(negedge clk);
        if (sel) req_b = 1'b0; else req_a = 1'b0;
        fall = 0;
        do begin @(posedge clk); #1; fall++; end while (cur_ack(sel) && fall < 60);
    endtask

    task automatic test_reset();
        rstn_a = 1'b0; rstn_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
        addr = '0; wdata = '0; wen = 1'b0; strb = '0;
        repeat (3) @(negedge clk);
        rstn_a = 1'b1; rstn_b = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            n_asserts++;
            if ({ack_a, busy_a, err_a, rd_a} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset_idle_a cyc %0d: ack=%b busy=%b err=%b rd=%h, required all 0", c, ack_a, busy_a, err_a, rd_a);
            end
            n_asserts++;
            if ({ack_b, busy_b, err_b, rd_b} !== 35'h0) begin
                n_fail++;
                $display("FAIL reset_idle_b cyc %0d: ack=%b busy=%b err=%b rd=%h, required all 0", c, ack_b, busy_b, err_b, rd_b);
            end
        end
    endtask

    task automatic test_full_word();
        logic [31:0] rd; logic er; int rise, fall;
        txn(0, 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, rd, er, rise, fall);
        mdl[widx(32'h10)] = 32'hDEADBEEF;
        n_asserts++; if (rise !== A_RISE) begin n_fail++; $display("FAIL fw_rise: got %0d required %0d", rise, A_RISE); end
        n_asserts++; if (fall !== A_FALL) begin n_fail++; $display("FAIL fw_fall: got %0d required %0d", fall, A_FALL); end
        n_asserts++; if (er !== 1'b0) begin n_fail++; $display("FAIL fw_err: got %b required 0", er); end
        n_asserts++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fw_wr_rd: got %h required DEADBEEF", rd); end
        n_asserts++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL fw_busy: got %b required 0", busy_a); end
        txn(0, 32'h10, 1'b0, 4'h0, 32'h0, rd, er, rise, fall);
        n_asserts++; if (rd !== mdl[4]) begin n_fail++; $display("FAIL fw_read: got %h required %h", rd, mdl[4]); end
        n_asserts++; if (er !== 1'b0) begin n_fail++; $display("FAIL fw_read_err: got %b required 0", er); end
    endtask

    task automatic test_strobes();
        logic [31:0] rd, d; logic er; int rise, fall;
        txn(0, 32'h20, 1'b1, 4'hF, 32'h11223344, rd, er, rise, fall);
        mdl[8] = 32'h11223344;
        txn(0, 32'h20, 1'b1, 4'b0100, 32'h00AA0000, rd, er, rise, fall);
        mdl[8] = merge(mdl[8], 32'h00AA0000, 4'b0100);
        n_asserts++; if (rd !== mdl[8]) begin n_fail++; $display("FAIL strb_merge_wr: got %h required %h", rd, mdl[8]); end
        txn(0, 32'h20, 1'b0, 4'h0, 32'h0, rd, er, rise, fall);
        n_asserts++; if (rd !== 32'h11AA3344) begin n_fail++; $display("FAIL strb_read: got %h required 11AA3344", rd); end
        d = $urandom();
        txn(0, 32'h20, 1'b1, 4'h0, d, rd, er, rise, fall);
        n_asserts++; if (rd !== mdl[8] || er !== 1'b0) begin n_fail++; $display("FAIL strb0_wr: got %h/%b required %h/0", rd, er, mdl[8]); end
        txn(0, 32'h20, 1'b0, 4'h0, 32'h0, rd, er, rise, fall);
        n_asserts++; if (rd !== mdl[8]) begin n_fail++; $display("FAIL strb0_read: got %h required %h", rd, mdl[8]); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, v; logic er; int rise, fall;
        v = $urandom();
        txn(0, 32'hFFC, 1'b1, 4'hF, v, rd, er, rise, fall);
        mdl[32'h3FF] = v;
        txn(0, 32'h0000_1000, 1'b0, 4'h0, 32'h0, rd, er, rise, fall);
        n_asserts++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL oor_read: got err=%b rd=%h required 1/0", er, rd); end
        n_asserts++; if (rise !== A_RISE) begin n_fail++; $display("FAIL oor_rise: got %0d required %0d", rise, A_RISE); end
        txn(0, 32'hFFFF_FFFC, 1'b1, 4'hF, ~v, rd, er, rise, fall);
        n_asserts++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL oor_write: got err=%b rd=%h required 1/0", er, rd); end
        txn(0, 32'hFFC, 1'b0, 4'h0, 32'h0, rd, er, rise, fall);
        n_asserts++; if (er !== 1'b0 || rd !== mdl[32'h3FF]) begin n_fail++; $display("FAIL oor_alias: got err=%b rd=%h required 0/%h", er, rd, mdl[32'h3FF]); end
    endtask

    task automatic test_hold_req();
        logic [31:0] v; int rise, fall, drops;
        v = $urandom();
        @(negedge clk);
        addr = 32'h14; wen = 1'b1; strb = 4'hF; wdata = v; req_a = 1'b1;
        rise = 0;
        do begin @(posedge clk); #1; rise++; end while (!ack_a && rise < 60);
        mdl[5] = v;
        n_asserts++; if (rise !== A_RISE) begin n_fail++; $display("FAIL hold_rise: got %0d required %0d", rise, A_RISE); end
        drops = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ack_a !== 1'b1 || busy_a !== 1'b1) drops++;
        end
        n_asserts++; if (drops !== 0) begin n_fail++; $display("FAIL hold_ack_stable: got %0d cycles without ack/busy required 0", drops); end
        n_asserts++; if (rd_a !== v) begin n_fail++; $display("FAIL hold_rd: got %h required %h", rd_a, v); end
        @(negedge clk); req_a = 1'b0;
        fall = 0;
        do begin @(posedge clk); #1; fall++; end while (ack_a && fall < 60);
        n_asserts++; if (fall !== A_FALL) begin n_fail++; $display("FAIL hold_fall: got %0d required %0d", fall, A_FALL); end
        repeat (10) begin @(posedge clk); #1; if (ack_a !== 1'b0 || busy_a !== 1'b0) drops++; end
        n_asserts++; if (drops !== 0) begin n_fail++; $display("FAIL hold_no_reaccess: got %0d busy/ack cycles required 0", drops); end
    endtask

    task automatic test_early_drop();
        int pulses; logic [31:0] cap; logic cap_er;
        @(negedge clk);
        addr = 32'h10; wen = 1'b0; strb = 4'h0; req_a = 1'b1;
        @(negedge clk); req_a = 1'b0;
        pulses = 0; cap = '0; cap_er = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (ack_a) begin pulses++; cap = rd_a; cap_er = err_a; end
        end
        n_asserts++; if (pulses !== 1) begin n_fail++; $display("FAIL early_pulse_len: got %0d required 1", pulses); end
        n_asserts++; if (cap !== mdl[4] || cap_er !== 1'b0) begin n_fail++; $display("FAIL early_data: got %h/%b required %h/0", cap, cap_er, mdl[4]); end
        n_asserts++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL early_busy: got %b required 0", busy_a); end
    endtask

    task automatic test_reset_during_ack();
        logic [31:0] v, rd; logic er; int rise, fall;
        v = $urandom();
        @(negedge clk);
        addr = 32'h30; wen = 1'b1; strb = 4'hF; wdata = v; req_a = 1'b1;
        rise = 0;
        do begin @(posedge clk); #1; rise++; end while (!ack_a && rise < 60);
        mdl[12] = v;
        @(negedge clk); rstn_a = 1'b0; req_a = 1'b0;
        #1;
        n_asserts++; if (ack_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_in_ack: got ack=%b busy=%b required 0/0", ack_a, busy_a); end
        @(negedge clk); rstn_a = 1'b1;
        txn(0, 32'h30, 1'b0, 4'h0, 32'h0, rd, er, rise, fall);
        n_asserts++; if (rd !== v || er !== 1'b0) begin n_fail++; $display("FAIL rst_in_ack_data: got %h/%b required %h/0", rd, er, v); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int rise, fall;
        for (int i = 0; i < 3; i++) begin
            mdl[i] = $urandom();
            txn(0, 32'(i * 4), 1'b1, 4'hF, mdl[i], rd, er, rise, fall);
        end
        for (int i = 0; i < 3; i++) begin
            txn(0, 32'(i * 4), 1'b0, 4'h0, 32'h0, rd, er, rise, fall);
            n_asserts++; if (rd !== mdl[i] || er !== 1'b0) begin n_fail++; $display("FAIL b2b_read %0d: got %h/%b required %h/0", i, rd, er, mdl[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, exp_rd; logic er, w, exp_er; logic [3:0] s; int rise, fall, i;
        for (int k = 0; k < 16; k++) begin
            mdl[k] = $urandom();
            txn(0, 32'(k * 4), 1'b1, 4'hF, mdl[k], rd, er, rise, fall);
        end
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) a = $urandom() | 32'h0000_1000;
            else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            d = $urandom();
            txn(0, a, w, s, d, rd, er, rise, fall);
            i = widx(a);
            if (out_of_range(a)) begin
                exp_rd = 32'h0; exp_er = 1'b1;
            end else begin
                exp_er = 1'b0;
                if (w) mdl[i] = merge(mdl[i], d, s);
                exp_rd = mdl[i];
            end
            n_asserts++;
            if (rd !== exp_rd || er !== exp_er || rise !== A_RISE || fall !== A_FALL) begin
                n_fail++;
                $display("FAIL rand %0d a=%h w=%b s=%h: got rd=%h err=%b rise=%0d fall=%0d required %h/%b/%0d/%0d",
                         n, a, w, s, rd, er, rise, fall, exp_rd, exp_er, A_RISE, A_FALL);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd, old; logic er; int rise, fall, acks;
        old = $urandom();
        txn(1, 32'h40, 1'b1, 4'hF, old, rd, er, rise, fall);
        n_asserts++; if (rise !== B_RISE) begin n_fail++; $display("FAIL b_rise: got %0d required %0d", rise, B_RISE); end
        n_asserts++; if (fall !== B_FALL) begin n_fail++; $display("FAIL b_fall: got %0d required %0d", fall, B_FALL); end
        @(negedge clk);
        addr = 32'h40; wen = 1'b1; strb = 4'hF; wdata = 32'hCAFEF00D; req_b = 1'b1;
        repeat (3 + 1 + 3) @(posedge clk);
        #1;
        n_asserts++; if (busy_b !== 1'b1 || ack_b !== 1'b0) begin n_fail++; $display("FAIL b_in_access: got busy=%b ack=%b required 1/0", busy_b, ack_b); end
        @(negedge clk); rstn_b = 1'b0; req_b = 1'b0;
        #1;
        n_asserts++; if (busy_b !== 1'b0 || ack_b !== 1'b0) begin n_fail++; $display("FAIL b_rst: got busy=%b ack=%b required 0/0", busy_b, ack_b); end
        repeat (2) @(negedge clk);
        rstn_b = 1'b1;
        acks = 0;
        repeat (15) begin @(posedge clk); #1; if (ack_b) acks++; end
        n_asserts++; if (acks !== 0) begin n_fail++; $display("FAIL b_no_ack: got %0d ack cycles required 0", acks); end
        txn(1, 32'h40, 1'b0, 4'h0, 32'h0, rd, er, rise, fall);
        n_asserts++; if (rd !== old || er !== 1'b0) begin n_fail++; $display("FAIL b_uncommitted: got %h/%b required %h/0", rd, er, old); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_strobes();
        test_out_of_range();
        test_hold_req();
        test_early_drop();
        test_reset_during_ack();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
